// File: rtl/decoder_s2.sv
// WS2812 receive stage 2: validates low phases, assembles 24-bit GRB pixels,
// detects the latch gap and hands pixels downstream through one holding register.
module decoder_s2 #(
  parameter int TLOW_MIN       = 6,
  parameter int TLOW_MAX       = 100,
  parameter int TRES_CYCLES    = 1000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int PIXIDX_W       = 12
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_decode_bit,
  input  logic                      i_valid,
  input  logic [9:0]                i_counter,
  input  logic                      i_rising,
  input  logic                      i_ready,
  output logic [BITS_PER_PIXEL-1:0] o_pixel,
  output logic                      o_pixel_valid,
  output logic [PIXIDX_W-1:0]       o_pixel_index,
  output logic                      o_frame_end,
  output logic                      o_error,
  output logic                      o_overrun
);

  localparam int CNT_W = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [9:0] TLOW_MIN_C = 10'(TLOW_MIN);
  localparam logic [9:0] TLOW_MAX_C = 10'(TLOW_MAX);
  localparam logic [9:0] TRES_C     = 10'(TRES_CYCLES);
  localparam logic [CNT_W-1:0] BPP_C = CNT_W'(BITS_PER_PIXEL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [BITS_PER_PIXEL-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PIXIDX_W-1:0]       idx_q, idx_d;

  logic [BITS_PER_PIXEL-1:0] pix_q, pix_d;
  logic [PIXIDX_W-1:0]       pix_idx_q, pix_idx_d;
  logic                      pix_vld_q, pix_vld_d;
  logic                      fe_q, fe_d;
  logic                      err_q, err_d;
  logic                      ovr_q, ovr_d;

  logic                      latch;
  logic                      low_ok;
  logic                      xfer;
  logic                      do_commit;
  logic                      end_frame;
  logic                      pix_done;
  logic [BITS_PER_PIXEL-1:0] shifted;
  logic [CNT_W-1:0]          cnt_inc;

  assign latch   = i_counter >= TRES_C;
  assign low_ok  = (i_counter >= TLOW_MIN_C) && (i_counter <= TLOW_MAX_C);
  assign xfer    = pix_vld_q & i_ready;
  assign shifted = {sr_q[BITS_PER_PIXEL-2:0], i_decode_bit};
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pix_d     = pix_q;
    pix_idx_d = pix_idx_q;
    pix_vld_d = pix_vld_q;
    fe_d      = 1'b0;
    err_d     = 1'b0;
    ovr_d     = ovr_q;
    do_commit = 1'b0;
    end_frame = 1'b0;
    pix_done  = 1'b0;

    if (xfer) begin
      pix_vld_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_rising) begin
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        // A rising edge wins over the latch gap; its low length is then illegal.
        if (i_rising) begin
          if (i_valid && low_ok) begin
            do_commit = 1'b1;
          end else begin
            err_d   = 1'b1;
            sr_d    = '0;
            cnt_d   = '0;
            state_d = S_ERR;
          end
        end else if (latch) begin
          do_commit = i_valid;
          end_frame = 1'b1;
        end
      end
      S_ERR: begin
        if (latch) begin
          fe_d    = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_commit) begin
      if (cnt_inc == BPP_C) begin
        pix_done = 1'b1;
        sr_d     = '0;
        cnt_d    = '0;
        idx_d    = idx_q + 1'b1;
        if (!pix_vld_q || xfer) begin
          pix_d     = shifted;
          pix_idx_d = idx_q;
          pix_vld_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_inc;
      end
    end

    if (end_frame) begin
      fe_d    = 1'b1;
      idx_d   = '0;
      sr_d    = '0;
      cnt_d   = '0;
      state_d = S_IDLE;
      if (!pix_done) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      pix_q     <= '0;
      pix_idx_q <= '0;
      pix_vld_q <= 1'b0;
      fe_q      <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pix_q     <= pix_d;
      pix_idx_q <= pix_idx_d;
      pix_vld_q <= pix_vld_d;
      fe_q      <= fe_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_pixel       = pix_q;
  assign o_pixel_valid = pix_vld_q;
  assign o_pixel_index = pix_idx_q;
  assign o_frame_end   = fe_q;
  assign o_error       = err_q;
  assign o_overrun     = ovr_q;

endmodule

// File: doc/decoder_s2.md
Name: decoder_s2

Overview:
- Stage 2 of the WS2812 receive pipeline. Sits directly downstream of the stage-1 high-cycle decoder.
- Validates each low-cycle duration and commits the stage-1 decoded bits into a 24-bit GRB pixel shift register, MSB first.
- Detects the reset/latch gap that ends a frame.
- Presents completed pixels on a valid/ready output with a single holding register; framing and timing errors are flagged.

Parameters:
- TLOW_MIN, 6, minimum legal low-phase length in clocks (inclusive).
- TLOW_MAX, 100, maximum legal low-phase length in clocks (inclusive).
- TRES_CYCLES, 1000, idle length in clocks that constitutes a latch/reset gap; must be > TLOW_MAX and ≤ 1023.
- BITS_PER_PIXEL, 24, bits assembled per pixel.
- PIXIDX_W, 12, width of the pixel index counter.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_decode_bit  in  1  stage-1 decoded bit value (registered on falling edge).
- i_valid  in  1  stage-1 high-cycle window result for the most recent high phase.
- i_counter  in  10  cycles since last line edge; saturates at 1023 upstream.
- i_rising  in  1  one-cycle pulse on a line rising edge; i_counter on that cycle = preceding low length.
- i_ready  in  1  downstream accepts pixel.
- o_pixel  out  BITS_PER_PIXEL  assembled pixel; first received bit at MSB.
- o_pixel_valid  out  1  holding register full.
- o_pixel_index  out  PIXIDX_W  index of pixel in o_pixel within the current frame.
- o_frame_end  out  1  one-cycle pulse on latch detection.
- o_error  out  1  one-cycle pulse on timing/framing error.
- o_overrun  out  1  sticky: pixel dropped because holding register was full.

Behaviour:
- Reset (i_reset_n low at a clock edge): state IDLE, shift register 0, bit count 0, pixel index counter 0. All outputs 0, including o_overrun. Reset mid-frame discards all partial data.
- Latch condition: i_counter ≥ TRES_CYCLES.
- State IDLE: on i_rising go to BIT. No commit, because the first rising has no preceding bit. The latch condition is ignored in IDLE, so o_frame_end does not re-fire during long idle.
- State BIT, on i_rising:
  - If i_valid=1 and TLOW_MIN ≤ i_counter ≤ TLOW_MAX: commit i_decode_bit. Shift left, new bit into LSB, bit count +1. Stay in BIT.
  - Otherwise: pulse o_error, clear shift register and bit count, go to ERR.
- State BIT, on latch condition:
  - Commit i_decode_bit if i_valid=1; the low length is implicitly legal.
  - Then pulse o_frame_end, reset the pixel index counter to 0, go to IDLE.
  - If i_valid=0, or bit count after the commit is nonzero (partial pixel): also pulse o_error and discard the partial pixel.
- State ERR: wait for the latch condition, then pulse o_frame_end, reset the index counter to 0, go to IDLE. Risings are ignored.
- Pixel completion: when a commit makes bit count reach BITS_PER_PIXEL:
  - bit count returns to 0;
  - if the holding register is empty, load o_pixel and o_pixel_index with the completed pixel and its index, and set o_pixel_valid;
  - if the holding register is full, drop the pixel and set o_overrun;
  - the index counter increments in both cases and wraps at 2^PIXIDX_W.
- Latency: o_pixel_valid rises on the cycle after the committing i_rising or latch cycle.
- Output handshake: pixel transfers on a cycle with o_pixel_valid & i_ready, and o_pixel_valid clears the next cycle. A new pixel completing on the same cycle as a transfer loads into the holding register with no overrun. o_pixel and o_pixel_index are held stable while o_pixel_valid=1 && !i_ready.
- Simultaneous i_rising and latch condition: i_rising takes priority; a legal low length is impossible in that case, so the error path applies.
- o_frame_end and o_error may pulse in the same cycle.

Test Plan:
- Single pixel 0xA5C30F: high 16/8 clocks (per stage-1 windows), low 10 clocks, then 1100-clock idle -> o_pixel=0xA5C30F, o_pixel_index=0, valid one cycle after the latch cycle. o_frame_end pulses once, o_error stays 0.
- Three pixels 0x123456, 0xFFFFFF, 0x000000 back-to-back with i_ready held 1 -> three transfers with indices 0, 1, 2, then o_frame_end; next frame starts at index 0.
- Low of 120 clocks after bit 5 -> o_error pulse on that rising, no pixel output. Subsequent risings ignored until latch; o_frame_end pulses at latch; next frame decodes correctly.
- i_ready held 0 across two completed pixels -> first pixel held stable, second dropped, o_overrun=1 and stays 1 until reset; later i_ready=1 transfers the first pixel.
- Frame ending after 10 bits -> o_frame_end and o_error pulse together, no o_pixel_valid.
- i_reset_n low for 1 cycle mid-pixel (bit 12) -> all outputs 0. The next rising is treated as a first rising, and the following 24-bit pixel decodes correctly.
